// File: rtl/nios_mem_arb_pkg.sv
// rtl/nios_mem_arb_pkg.sv - shared types and default widths for the on-chip RAM arbiter
// Port identifiers and the read-return tracking record.
package nios_mem_arb_pkg;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;

   typedef enum logic {
      PORT_M0 = 1'b0,
      PORT_M1 = 1'b1
   } arb_port_e;

   typedef struct packed {
      logic      valid;
      arb_port_e owner;
   } rd_pend_t;

endpackage

// File: rtl/nios_onchip_mem_arbiter_if.sv
// rtl/nios_onchip_mem_arbiter_if.sv - Avalon-MM requester port bundle
// One instance per requester; the arbiter takes the slave view.
interface nios_onchip_mem_arbiter_if #(
   parameter int ADDR_W = nios_mem_arb_pkg::ADDR_W,
   parameter int DATA_W = nios_mem_arb_pkg::DATA_W,
   parameter int BE_W   = DATA_W / 8
);

   logic [ADDR_W-1:0] address;
   logic [BE_W-1:0]   byteenable;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/nios_rr_arbiter2.sv
// rtl/nios_rr_arbiter2.sv - two-way round-robin grant with last-grant memory
// Combinational one-hot grant; last_grant resets to port 1 so port 0 wins the first conflict.
module nios_rr_arbiter2
   import nios_mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   input  logic       ack,
   output logic [1:0] grant
);

   arb_port_e last_grant_q;
   arb_port_e last_grant_d;

   always_comb begin
      grant = 2'b00;
      if (en) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_q == PORT_M1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (ack && (grant != 2'b00)) begin
         last_grant_d = grant[1] ? PORT_M1 : PORT_M0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= PORT_M1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/nios_onchip_mem_arbiter.sv
// rtl/nios_onchip_mem_arbiter.sv - shares one single-port on-chip RAM between two Avalon-MM requesters
// One access per cycle, round-robin on conflict, fixed 1-cycle read return to the owning port.
module nios_onchip_mem_arbiter #(
   parameter int ADDR_W = nios_mem_arb_pkg::ADDR_W,
   parameter int DATA_W = nios_mem_arb_pkg::DATA_W,
   parameter int BE_W   = DATA_W / 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   freeze,
   nios_onchip_mem_arbiter_if.slave m0,
   nios_onchip_mem_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]      ram_address,
   output logic [BE_W-1:0]        ram_byteenable,
   output logic                   ram_chipselect,
   output logic                   ram_write,
   output logic [DATA_W-1:0]      ram_writedata,
   input  logic [DATA_W-1:0]      ram_readdata
);

   import nios_mem_arb_pkg::*;

   logic [1:0] req;
   logic [1:0] grant;
   logic       arb_en;
   logic       granted;

   logic [ADDR_W-1:0] sel_address;
   logic [BE_W-1:0]   sel_byteenable;
   logic [DATA_W-1:0] sel_writedata;
   logic              sel_write;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   rd_pend_t          rd_pend_q, rd_pend_d;

   assign req    = {m1.read | m1.write, m0.read | m0.write};
   assign arb_en = ~freeze & ~reset;

   nios_rr_arbiter2 u_rr (
      .clk   (clk),
      .rst   (reset),
      .req   (req),
      .en    (arb_en),
      .ack   (1'b1),
      .grant (grant)
   );

   assign granted = |grant;

   always_comb begin
      sel_address    = m0.address;
      sel_byteenable = m0.byteenable;
      sel_writedata  = m0.writedata;
      sel_write      = m0.write;
      if (grant[1]) begin
         sel_address    = m1.address;
         sel_byteenable = m1.byteenable;
         sel_writedata  = m1.writedata;
         sel_write      = m1.write;
      end
   end

   // Without a grant the RAM bus parks on the last granted values to avoid toggling.
   always_comb begin
      ram_chipselect = granted;
      ram_write      = granted & sel_write;
      ram_address    = granted ? sel_address    : addr_q;
      ram_byteenable = granted ? sel_byteenable : be_q;
      ram_writedata  = granted ? sel_writedata  : wdata_q;
      addr_d         = ram_address;
      be_d           = ram_byteenable;
      wdata_d        = ram_writedata;
   end

   // A request with both read and write high counts as a write, so no read is tracked.
   always_comb begin
      rd_pend_d.valid = granted & ~sel_write;
      rd_pend_d.owner = grant[1] ? PORT_M1 : PORT_M0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         rd_pend_q <= '0;
      end else begin
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   assign m0.waitrequest   = req[0] & ~grant[0];
   assign m1.waitrequest   = req[1] & ~grant[1];
   assign m0.readdatavalid = rd_pend_q.valid & (rd_pend_q.owner == PORT_M0);
   assign m1.readdatavalid = rd_pend_q.valid & (rd_pend_q.owner == PORT_M1);
   assign m0.readdata      = ram_readdata;
   assign m1.readdata      = ram_readdata;

endmodule

// File: tb/tb_nios_onchip_mem_arbiter.sv
// tb/tb_nios_onchip_mem_arbiter.sv - self-checking bench for the two-port on-chip RAM arbiter
// A behavioural RAM plus a cycle-level reference model of the sharing rules.
module tb_nios_onchip_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        freeze;
   logic [10:0] ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect;
   logic        ram_write;
   logic [31:0] ram_writedata;
   logic [31:0] ram_readdata;
   logic [31:0] ram_arr [0:2047];

   nios_onchip_mem_arbiter_if m0_if ();
   nios_onchip_mem_arbiter_if m1_if ();

   nios_onchip_mem_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .freeze         (freeze),
      .m0             (m0_if),
      .m1             (m1_if),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_writedata  (ram_writedata),
      .ram_readdata   (ram_readdata)
   );

   always #5 clk = ~clk;

   // Single-port RAM: write at the edge, registered read data valid the next cycle.
   always @(posedge clk) begin
      if (ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b]) ram_arr[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         end else begin
            ram_readdata <= ram_arr[ram_address];
         end
      end
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [31:0] ref_mem [0:2047];
   int          ref_last;
   bit          ref_pv;
   int          ref_po;
   logic [31:0] ref_pd;
   logic [10:0] ref_hold_addr;

   // {ram_address, wait0, wait1, chipselect, write, rv0, rv1}
   logic [16:0] obs_ctl, exp_ctl;
   logic [31:0] obs_d0, obs_d1, exp_d;

   task automatic set_port(input int p, input bit rd, input bit wr, input logic [10:0] a,
                           input logic [31:0] d, input logic [3:0] be);
      if (p == 0) begin
         m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
         m0_if.writedata = d; m0_if.byteenable = be;
      end else begin
         m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
         m1_if.writedata = d; m1_if.byteenable = be;
      end
   endtask

   task automatic idle_ports();
      set_port(0, 0, 0, 11'h0, 32'h0, 4'h0);
      set_port(1, 0, 0, 11'h0, 32'h0, 4'h0);
   endtask

   // Predict this cycle from the sharing rules, sample the DUT mid-cycle, then advance the model.
   task automatic run_cycle();
      bit          r0, r1;
      int          win;
      logic [10:0] wa;
      logic        wwr;
      logic [31:0] wd;
      logic [3:0]  wbe;
      @(negedge clk);
      cyc++;
      r0 = m0_if.read | m0_if.write;
      r1 = m1_if.read | m1_if.write;
      if (reset || freeze)  win = -1;
      else if (r0 && r1)    win = 1 - ref_last;
      else if (r0)          win = 0;
      else if (r1)          win = 1;
      else                  win = -1;
      wa = ref_hold_addr; wwr = 1'b0; wd = '0; wbe = '0;
      if (win == 0) begin
         wa = m0_if.address; wwr = m0_if.write; wd = m0_if.writedata; wbe = m0_if.byteenable;
      end else if (win == 1) begin
         wa = m1_if.address; wwr = m1_if.write; wd = m1_if.writedata; wbe = m1_if.byteenable;
      end
      exp_ctl = {wa, r0 && (win != 0), r1 && (win != 1), win >= 0, wwr,
                 ref_pv && (ref_po == 0), ref_pv && (ref_po == 1)};
      exp_d   = ref_pd;
      obs_ctl = {ram_address, m0_if.waitrequest, m1_if.waitrequest, ram_chipselect, ram_write,
                 m0_if.readdatavalid, m1_if.readdatavalid};
      obs_d0  = m0_if.readdata;
      obs_d1  = m1_if.readdata;
      @(posedge clk);
      if (reset) begin
         ref_last = 1; ref_pv = 0; ref_hold_addr = '0;
      end else begin
         ref_pv = 0;
         if (win >= 0) begin
            ref_last = win;
            ref_hold_addr = wa;
            if (wwr) begin
               for (int b = 0; b < 4; b++)
                  if (wbe[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
            end else begin
               ref_pv = 1; ref_po = win; ref_pd = ref_mem[wa];
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      set_port(0, 1, 0, 11'h003, 32'h0, 4'hF);
      set_port(1, 1, 0, 11'h004, 32'h0, 4'hF);
      run_cycle();
      checks++;
      if (obs_ctl !== exp_ctl) begin
         failures++; $display("FAIL reset_ctl cyc=%0d got=%h exp=%h", cyc, obs_ctl, exp_ctl);
      end
      checks++;
      if (obs_ctl !== 17'b00000000000_11_0_0_0_0) begin
         failures++; $display("FAIL reset_values cyc=%0d got=%h exp=%h", cyc, obs_ctl, 17'h00030);
      end
      reset = 1'b0;
      idle_ports();
   endtask

   task automatic test_write_read();
      set_port(0, 0, 1, 11'h005, 32'hDEADBEEF, 4'hF);
      run_cycle();
      checks++;
      if (obs_ctl !== exp_ctl) begin
         failures++; $display("FAIL wr_ctl cyc=%0d got=%h exp=%h", cyc, obs_ctl, exp_ctl);
      end
      set_port(0, 1, 0, 11'h005, 32'h0, 4'h0);
      run_cycle();
      checks++;
      if (obs_ctl !== exp_ctl) begin
         failures++; $display("FAIL rd_ctl cyc=%0d got=%h exp=%h", cyc, obs_ctl, exp_ctl);
      end
      idle_ports();
      run_cycle();
      checks++;
      if (obs_ctl !== exp_ctl) begin
         failures++; $display("FAIL rd_ret_ctl cyc=%0d got=%h exp=%h", cyc, obs_ctl, exp_ctl);
      end
      checks++;
      if (obs_ctl[1:0] !== 2'b10 || obs_d0 !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL rd_ret_data cyc=%0d got_valid=%b got=%h exp_valid=10 exp=deadbeef",
                  cyc, obs_ctl[1:0], obs_d0);
      end
   endtask

   task automatic test_contention();
      set_port(0, 0, 1, 11'h010, 32'h1010_1010, 4'hF);
      run_cycle();
      set_port(0, 0, 0, 11'h010, 32'h0, 4'h0);
      set_port(1, 0, 1, 11'h020, 32'h2020_2020, 4'hF);
      run_cycle();
      set_port(0, 1, 0, 11'h010, 32'h0, 4'h0);
      set_port(1, 1, 0, 11'h020, 32'h0, 4'h0);
      for (int i = 0; i < 9; i++) begin
         if (i == 8) idle_ports();
         run_cycle();
         checks++;
         if (obs_ctl !== exp_ctl) begin
            failures++; $display("FAIL cont_ctl cyc=%0d got=%h exp=%h", cyc, obs_ctl, exp_ctl);
         end
         if (i < 8) begin
            checks++;
            if (obs_ctl[5:4] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
               failures++; $display("FAIL cont_order cyc=%0d waits=%b", cyc, obs_ctl[5:4]);
            end
         end
         if (i > 0) begin
            checks++;
            if ((obs_ctl[1] && obs_d0 !== 32'h1010_1010) || (obs_ctl[0] && obs_d1 !== 32'h2020_2020)) begin
               failures++; $display("FAIL cont_data cyc=%0d got0=%h got1=%h", cyc, obs_d0, obs_d1);
            end
         end
      end
   endtask

   task automatic test_byte_lanes();
      set_port(0, 0, 1, 11'h030, 32'h11223344, 4'hF);
      run_cycle();
      set_port(0, 0, 0, 11'h0, 32'h0, 4'h0);
      set_port(1, 0, 1, 11'h030, 32'hAABBCCDD, 4'h5);
      run_cycle();
      set_port(1, 1, 0, 11'h030, 32'h0, 4'h0);
      run_cycle();
      idle_ports();
      run_cycle();
      checks++;
      if (obs_ctl !== exp_ctl) begin
         failures++; $display("FAIL be_ctl cyc=%0d got=%h exp=%h", cyc, obs_ctl, exp_ctl);
      end
      checks++;
      if (obs_ctl[1:0] !== 2'b01 || obs_d1 !== 32'h11BB33DD) begin
         failures++;
         $display("FAIL be_data cyc=%0d got_valid=%b got=%h exp=11bb33dd", cyc, obs_ctl[1:0], obs_d1);
      end
   endtask

   task automatic test_freeze();
      int w;
      set_port(0, 1, 0, 11'h010, 32'h0, 4'h0);
      set_port(1, 1, 0, 11'h020, 32'h0, 4'h0);
      run_cycle();
      w = obs_ctl[5] ? 1 : 0;
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_cycle();
         checks++;
         if (obs_ctl !== exp_ctl) begin
            failures++; $display("FAIL frz_ctl cyc=%0d got=%h exp=%h", cyc, obs_ctl, exp_ctl);
         end
         checks++;
         if (obs_ctl[5:3] !== 3'b110) begin
            failures++; $display("FAIL frz_hold cyc=%0d got=%b exp=110", cyc, obs_ctl[5:3]);
         end
         if (i == 0) begin
            checks++;
            if (obs_ctl[1-w] !== 1'b1) begin
               failures++; $display("FAIL frz_return cyc=%0d valids=%b owner=%0d", cyc, obs_ctl[1:0], w);
            end
         end
      end
      freeze = 1'b0;
      run_cycle();
      checks++;
      if (obs_ctl[5-(1-w)] !== 1'b0 || obs_ctl[5-w] !== 1'b1) begin
         failures++; $display("FAIL frz_resume cyc=%0d waits=%b prev_winner=%0d", cyc, obs_ctl[5:4], w);
      end
      idle_ports();
      run_cycle();
   endtask

   task automatic test_reset_mid();
      set_port(0, 1, 0, 11'h010, 32'h0, 4'h0);
      run_cycle();
      idle_ports();
      #2 reset = 1'b1;
      #1;
      checks++;
      if (m0_if.readdatavalid !== 1'b0 || ram_chipselect !== 1'b0 || ram_write !== 1'b0 ||
          ram_address !== 11'h0 || ram_byteenable !== 4'h0 || ram_writedata !== 32'h0) begin
         failures++;
         $display("FAIL rst_async rv0=%b cs=%b wr=%b addr=%h be=%h wd=%h exp all zero",
                  m0_if.readdatavalid, ram_chipselect, ram_write, ram_address, ram_byteenable, ram_writedata);
      end
      ref_pv = 0; ref_last = 1; ref_hold_addr = '0;
      run_cycle();
      checks++;
      if (obs_ctl !== exp_ctl) begin
         failures++; $display("FAIL rst_hold_ctl cyc=%0d got=%h exp=%h", cyc, obs_ctl, exp_ctl);
      end
      reset = 1'b0;
      set_port(0, 1, 0, 11'h020, 32'h0, 4'h0);
      set_port(1, 1, 0, 11'h010, 32'h0, 4'h0);
      run_cycle();
      checks++;
      if (obs_ctl[5:4] !== 2'b01) begin
         failures++; $display("FAIL rst_first_conflict cyc=%0d waits=%b exp=01", cyc, obs_ctl[5:4]);
      end
      idle_ports();
      run_cycle();
   endtask

   task automatic test_random();
      bit rd, wr;
      int k;
      for (int a = 0; a < 16; a++) begin
         set_port(a % 2, 0, 1, 11'(a), $urandom, 4'hF);
         set_port(1 - (a % 2), 0, 0, 11'h0, 32'h0, 4'h0);
         run_cycle();
      end
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!obs_ctl[5-p]) begin
               k  = $urandom_range(0, 3);
               rd = (k == 1) || (k == 3);
               wr = (k == 2) || (k == 3);
               set_port(p, rd, wr, 11'($urandom_range(0, 15)), $urandom, 4'($urandom));
            end
         end
         freeze = ($urandom_range(0, 7) == 0);
         run_cycle();
         checks++;
         if (obs_ctl !== exp_ctl) begin
            failures++; $display("FAIL rnd_ctl cyc=%0d got=%h exp=%h", cyc, obs_ctl, exp_ctl);
         end
         if (exp_ctl[1] || exp_ctl[0]) begin
            checks++;
            if ((exp_ctl[1] ? obs_d0 : obs_d1) !== exp_d) begin
               failures++; $display("FAIL rnd_data cyc=%0d got0=%h got1=%h exp=%h", cyc, obs_d0, obs_d1, exp_d);
            end
         end
      end
      freeze = 1'b0;
      idle_ports();
      run_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      freeze = 1'b0;
      idle_ports();
      ref_last = 1; ref_pv = 0; ref_po = 0; ref_pd = '0; ref_hold_addr = '0;
      test_reset();
      test_write_read();
      test_contention();
      test_byte_lanes();
      test_freeze();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
